// File: rtl/kmeans_accumulate.sv
// kmeans_accumulate: per-centroid feature sum/count accumulator with an ordered dump of one record per centroid
// Ports:
//   clk, rst (sync, active high), clear (one-cycle epoch restart)
//   in_valid/in_ready/in_index/in_point/in_last : classified points, in_index is 1-based
//   out_valid/out_ready/out_centroid/out_sums/out_count/out_last : dump records, centroids 1..CENTROID_NUM
//   idx_err : one-cycle pulse the cycle after an accepted out-of-range index
//   sat_flag : sticky saturation flag, present only with KMEANS_ACC_SAT_EN (sums/counts saturate instead of wrapping)
module kmeans_accumulate #(
  parameter int CENTROID_NUM = 8,
  parameter int FEAT_NUM = 4,
  parameter int FEAT_WIDTH = 16,
  parameter int SUM_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_index,
  input  logic [FEAT_NUM*FEAT_WIDTH-1:0] in_point,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    out_centroid,
  output logic [FEAT_NUM*SUM_WIDTH-1:0] out_sums,
  output logic [CNT_WIDTH-1:0]          out_count,
  output logic                          out_last,
  output logic                          idx_err
`ifdef KMEANS_ACC_SAT_EN
  ,
  output logic                          sat_flag
`endif
);
  typedef enum logic {ACCUM, DUMP} state_t;
  localparam logic [3:0] LAST_IDX = 4'(CENTROID_NUM);
  state_t state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [SUM_WIDTH-1:0] sums_q [CENTROID_NUM][FEAT_NUM];
  logic [SUM_WIDTH-1:0] sums_d [CENTROID_NUM][FEAT_NUM];
  logic [CNT_WIDTH-1:0] cnt_q [CENTROID_NUM];
  logic [CNT_WIDTH-1:0] cnt_d [CENTROID_NUM];
  logic idx_err_q, idx_err_d;
  logic accept, idx_ok, add_en, done;
`ifdef KMEANS_ACC_SAT_EN
  logic sat_q, sat_hit;
  logic [SUM_WIDTH:0] sw;
  logic [CNT_WIDTH:0] cw;
  assign sat_flag = sat_q;
`endif
  assign accept = in_valid & in_ready;
  assign idx_ok = (in_index != 4'd0) && (in_index <= LAST_IDX);
  assign add_en = accept & idx_ok & ~clear;
  assign done = out_valid & out_ready & out_last;
  assign idx_err_d = accept & ~idx_ok & ~clear;
  assign ptr_d = (state_q == ACCUM) ? 4'd1 : (out_valid && out_ready) ? ptr_q + 4'd1 : ptr_q;
  always_ff @(posedge clk) state_q <= rst ? ACCUM : state_d;
  always_comb
    state_d = clear ? ACCUM :
              (state_q == ACCUM) ? ((accept && in_last) ? DUMP : ACCUM) :
              done ? ACCUM : DUMP;
  // clear also blanks the record in its own cycle so no handshake can complete alongside it
  always_comb begin
    in_ready = state_q == ACCUM;
    out_valid = (state_q == DUMP) && !clear;
    out_centroid = out_valid ? ptr_q : 4'd0;
    out_last = out_valid && (ptr_q == LAST_IDX);
    out_count = '0;
    out_sums = '0;
    for (int c = 0; c < CENTROID_NUM; c++)
      if (out_valid && ptr_q == 4'(c + 1)) begin
        out_count = cnt_q[c];
        for (int f = 0; f < FEAT_NUM; f++) out_sums[f*SUM_WIDTH +: SUM_WIDTH] = sums_q[c][f];
      end
    idx_err = idx_err_q;
  end
  always_comb begin
    sums_d = sums_q;
    cnt_d = cnt_q;
`ifdef KMEANS_ACC_SAT_EN
    sat_hit = 1'b0;
    sw = '0;
    cw = '0;
`endif
    for (int c = 0; c < CENTROID_NUM; c++)
      if (clear || done) begin
        cnt_d[c] = '0;
        for (int f = 0; f < FEAT_NUM; f++) sums_d[c][f] = '0;
      end else if (add_en && in_index == 4'(c + 1)) begin
`ifdef KMEANS_ACC_SAT_EN
        cw = {1'b0, cnt_q[c]} + (CNT_WIDTH+1)'(1);
        cnt_d[c] = cw[CNT_WIDTH] ? '1 : cw[CNT_WIDTH-1:0];
        sat_hit = sat_hit | cw[CNT_WIDTH];
        for (int f = 0; f < FEAT_NUM; f++) begin
          sw = {1'b0, sums_q[c][f]} + (SUM_WIDTH+1)'(in_point[f*FEAT_WIDTH +: FEAT_WIDTH]);
          sums_d[c][f] = sw[SUM_WIDTH] ? '1 : sw[SUM_WIDTH-1:0];
          sat_hit = sat_hit | sw[SUM_WIDTH];
        end
`else
        cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
        for (int f = 0; f < FEAT_NUM; f++)
          sums_d[c][f] = sums_q[c][f] + SUM_WIDTH'(in_point[f*FEAT_WIDTH +: FEAT_WIDTH]);
`endif
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CENTROID_NUM; c++) begin
        cnt_q[c] <= '0;
        for (int f = 0; f < FEAT_NUM; f++) sums_q[c][f] <= '0;
      end
      ptr_q <= 4'd1;
      idx_err_q <= 1'b0;
    end else begin
      sums_q <= sums_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      idx_err_q <= idx_err_d;
    end
  end
`ifdef KMEANS_ACC_SAT_EN
  always_ff @(posedge clk) sat_q <= (rst || clear || done) ? 1'b0 : (sat_q | sat_hit);
`endif
endmodule

// File: tb/tb_kmeans_accumulate.sv
// tb_kmeans_accumulate: scoreboard bench for kmeans_accumulate with directed points and hand-computed dump records
module tb_kmeans_accumulate;
  localparam int CN = 8, FN = 4, FW = 16, SW = 17, CW = 16;
  logic clk = 1'b0;
  logic rst, clear, in_valid, in_ready, in_last, out_valid, out_ready, out_last, idx_err;
  logic [3:0] in_index, out_centroid;
  logic [FN*FW-1:0] in_point;
  logic [FN*SW-1:0] out_sums;
  logic [CW-1:0] out_count;
`ifdef KMEANS_ACC_SAT_EN
  logic sat_flag;
`endif
  typedef struct packed {
    logic [3:0] c;
    logic [FN*SW-1:0] s;
    logic [CW-1:0] n;
    logic l;
  } rec_t;
  rec_t exp_q[$];
  rec_t act_r, exp_r;
  int total = 0, bad = 0, errs = 0;

  always #5 clk = ~clk;

  kmeans_accumulate #(.CENTROID_NUM(CN), .FEAT_NUM(FN), .FEAT_WIDTH(FW), .SUM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_point(in_point), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_centroid(out_centroid), .out_sums(out_sums),
    .out_count(out_count), .out_last(out_last), .idx_err(idx_err)
`ifdef KMEANS_ACC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  function automatic rec_t mk(int c, int s0, int s1, int s2, int s3, int n);
    rec_t r;
    r.c = 4'(c);
    r.s = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    r.n = CW'(n);
    r.l = (c == CN);
    return r;
  endfunction

  task automatic push_zero_except(int hot, int s0, int s1, int s2, int s3, int n);
    for (int c = 1; c <= CN; c++) exp_q.push_back(c == hot ? mk(c, s0, s1, s2, s3, n) : mk(c, 0, 0, 0, 0, 0));
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(int idx, int f0, int f1, int f2, int f3, bit last);
    in_valid = 1'b1;
    in_index = 4'(idx);
    in_point = {FW'(f3), FW'(f2), FW'(f1), FW'(f0)};
    in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_accum();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 200);
    chk("accum_return", in_ready, 1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (idx_err) errs++;
      if (out_valid && out_ready) begin
        act_r = {out_centroid, out_sums, out_count, out_last};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rec_unexpected: got %h want none", act_r);
        end else begin
          exp_r = exp_q.pop_front();
          if (act_r !== exp_r) begin
            bad++;
            $display("FAIL rec_c%0d: got %h want %h", exp_r.c, act_r, exp_r);
          end
        end
      end
    end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_index = '0; in_point = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_centroid", out_centroid, 0);
    chk("rst_out_sums", out_sums, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_idx_err", idx_err, 0);
    @(posedge clk); #1;

    exp_q.push_back(mk(1, 11, 22, 33, 44, 2));
    for (int c = 2; c < CN; c++) exp_q.push_back(mk(c, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(8, 5, 5, 5, 5, 1));
    send(1, 1, 2, 3, 4, 0);
    send(1, 10, 20, 30, 40, 0);
    send(8, 5, 5, 5, 5, 1);
    @(negedge clk);
    chk("first_rec_valid", out_valid, 1);
    wait_accum();

    errs = 0;
    send(0, 7, 7, 7, 7, 0);
    @(negedge clk);
    chk("idx0_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(9, 7, 7, 7, 7, 0);
    @(negedge clk);
    chk("idx9_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("idx_err_pulses", errs, 2);
    push_zero_except(0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 1);
    wait_accum();

    push_zero_except(3, 1, 2, 3, 4, 1);
    send(3, 1, 2, 3, 4, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_centroid", out_centroid, 3);
      chk("stall_sums", out_sums, {17'd4, 17'd3, 17'd2, 17'd1});
      chk("stall_count", out_count, 1);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_accum();

    in_valid = 1'b1; in_index = 4'd2; in_point = {16'd9, 16'd9, 16'd9, 16'd9}; in_last = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("clear_in_ready", in_ready, 1);
    chk("clear_out_valid", out_valid, 0);
    @(posedge clk); #1;
    push_zero_except(0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 1);
    wait_accum();

`ifdef KMEANS_ACC_SAT_EN
    push_zero_except(4, 'h1FFFF, 0, 0, 0, 3);
`else
    push_zero_except(4, 'h0FFFD, 0, 0, 0, 3);
`endif
    send(4, 'hFFFF, 0, 0, 0, 0);
    send(4, 'hFFFF, 0, 0, 0, 0);
    send(4, 'hFFFF, 0, 0, 0, 1);
`ifdef KMEANS_ACC_SAT_EN
    @(negedge clk);
    chk("sat_flag_set", sat_flag, 1);
`endif
    wait_accum();
`ifdef KMEANS_ACC_SAT_EN
    chk("sat_flag_cleared", sat_flag, 0);
`endif

    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 1, 1, 1, 1, 1));
    exp_q.push_back(mk(3, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 0, 0));
    send(2, 1, 1, 1, 1, 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rst_at_centroid", out_centroid, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    push_zero_except(6, 2, 4, 6, 8, 1);
    send(6, 2, 4, 6, 8, 1);
    wait_accum();

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
